// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX controller and its sampler/checker
// neighbours. master is the controller side, slave is the datapath side.
interface uart_rx_ctrl_if #(
   parameter int unsigned prescale_w = 6,
   parameter int unsigned bit_cnt_w  = 4
);
   logic                  rx_in;
   logic                  par_en;
   logic [prescale_w-1:0] prescale;
   logic                  strt_glitch;
   logic                  par_err;
   logic                  stp_err;
   logic [prescale_w-1:0] edge_cnt;
   logic [bit_cnt_w-1:0]  bit_cnt;
   logic                  dat_samp_en;
   logic                  deser_en;
   logic                  strt_chk_en;
   logic                  par_chk_en;
   logic                  stp_chk_en;
   logic                  data_valid;

   modport master (
      input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
      output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
             par_chk_en, stp_chk_en, data_valid
   );

   modport slave (
      output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
      input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
             par_chk_en, stp_chk_en, data_valid
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: tracks oversampled bit timing of a frame
// (start, data, optional parity, stop), pulses the sampler/checker
// enables and flags each clean frame with a one-cycle data_valid.
module uart_rx_ctrl #(
   parameter int unsigned frame_data = 8,
   parameter int unsigned prescale_w = 6,
   parameter int unsigned bit_cnt_w  = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [prescale_w-1:0] r_edge_cnt;
   logic [prescale_w-1:0] w_next_edge;
   logic [prescale_w-1:0] r_prescale_q;
   logic [prescale_w-1:0] w_prescale_eff;
   logic [bit_cnt_w-1:0]  r_bit_cnt;
   logic [bit_cnt_w-1:0]  w_next_bit;
   logic                  r_par_en_q;
   logic                  r_err_latch;
   logic                  w_err_next;
   logic                  w_load;
   logic                  w_end_of_bit;
   logic                  w_in_frame;
   logic                  w_next_in_frame;
   logic                  w_chk_next;
   logic                  r_dat_samp_en;
   logic                  r_deser_en;
   logic                  r_strt_chk_en;
   logic                  r_par_chk_en;
   logic                  r_stp_chk_en;
   logic                  r_data_valid;

   assign w_end_of_bit    = (r_edge_cnt == r_prescale_q - prescale_w'(1));
   assign w_in_frame      = (r_state inside {START, DATA, PARITY, STOP});
   assign w_next_in_frame = (w_next_state inside {START, DATA, PARITY, STOP});

   // Outputs are registered from next-cycle values, so each pulse lines up
   // with the cycle in which edge_cnt actually shows the check point.
   assign w_prescale_eff = w_load ? bus.prescale : r_prescale_q;
   assign w_chk_next     = (w_next_edge == (w_prescale_eff >> 1) + prescale_w'(2));

   // Next-state, counter and error-flag logic
   always_comb begin
      w_next_state = r_state;
      w_next_edge  = '0;
      w_next_bit   = '0;
      w_load       = 1'b0;
      w_err_next   = r_err_latch;

      if (w_in_frame) begin
         if (w_end_of_bit) begin
            w_next_edge = '0;
            w_next_bit  = r_bit_cnt + bit_cnt_w'(1);
         end else begin
            w_next_edge = r_edge_cnt + prescale_w'(1);
            w_next_bit  = r_bit_cnt;
         end
      end

      case (r_state)
         IDLE, DONE: begin
            w_next_state = IDLE;
            if (!bus.rx_in) begin
               w_next_state = START;
               w_load       = 1'b1;
            end
         end
         START: begin
            if (w_end_of_bit) begin
               if (bus.strt_glitch) begin
                  w_next_state = IDLE;
                  w_next_edge  = '0;
                  w_next_bit   = '0;
               end else begin
                  w_next_state = DATA;
               end
            end
         end
         DATA: begin
            if (w_end_of_bit && (r_bit_cnt == bit_cnt_w'(frame_data)))
               w_next_state = r_par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bus.par_err)
               w_err_next = 1'b1;
            if (w_end_of_bit)
               w_next_state = STOP;
         end
         STOP: begin
            if (bus.stp_err)
               w_err_next = 1'b1;
            if (w_end_of_bit) begin
               w_next_state = DONE;
               w_next_edge  = '0;
               w_next_bit   = '0;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      if (w_load)
         w_err_next = 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Counters, latched frame settings, error latch and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_edge_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_prescale_q  <= '0;
         r_par_en_q    <= 1'b0;
         r_err_latch   <= 1'b0;
         r_dat_samp_en <= 1'b0;
         r_deser_en    <= 1'b0;
         r_strt_chk_en <= 1'b0;
         r_par_chk_en  <= 1'b0;
         r_stp_chk_en  <= 1'b0;
         r_data_valid  <= 1'b0;
      end else begin
         r_edge_cnt  <= w_next_edge;
         r_bit_cnt   <= w_next_bit;
         r_err_latch <= w_err_next;
         if (w_load) begin
            r_prescale_q <= bus.prescale;
            r_par_en_q   <= bus.par_en;
         end
         r_dat_samp_en <= w_next_in_frame;
         r_strt_chk_en <= (w_next_state == START)  && w_chk_next;
         r_deser_en    <= (w_next_state == DATA)   && w_chk_next;
         r_par_chk_en  <= (w_next_state == PARITY) && w_chk_next;
         r_stp_chk_en  <= (w_next_state == STOP)   && w_chk_next;
         r_data_valid  <= (w_next_state == DONE)   && !w_err_next;
      end
   end

   assign bus.edge_cnt    = r_edge_cnt;
   assign bus.bit_cnt     = r_bit_cnt;
   assign bus.dat_samp_en = r_dat_samp_en;
   assign bus.deser_en    = r_deser_en;
   assign bus.strt_chk_en = r_strt_chk_en;
   assign bus.par_chk_en  = r_par_chk_en;
   assign bus.stp_chk_en  = r_stp_chk_en;
   assign bus.data_valid  = r_data_valid;

endmodule
